bus_xfer_ctrl: RTL and testbench

Sequencer that moves one word per request across the shared N-bit tri-state bus between the bank of load-enabled N-bit registers, or from the external input port into a register.
- Sits directly upstream of the register bank: generates the one-hot output-enable (bus driver select) and one-hot load strobes those registers consume.
- Guarantees single-driver bus ownership, a settle interval before load, and a registered done/err handshake to the requester.

---
 rtl/bus_xfer_ctrl.sv | 126 ++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_ctrl.sv
// One-word-per-request bus sequencer: selects a single bus driver, waits SETTLE
// cycles, strobes the destination load, then reports done (or err on a bad request).
module bus_xfer_ctrl #(
  parameter int N      = 8,
  parameter int R      = 4,
  parameter int SETTLE = 1,
  localparam int SW    = $clog2(R + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [SW-1:0] src,
  input  logic [SW-1:0] dst,
  input  logic [N-1:0]  din,
  inout  wire  [N-1:0]  bus,
  output logic [R-1:0]  oe,
  output logic [R-1:0]  load,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [N-1:0]  bus_q
);

  // Handshake: req is sampled only while IDLE; every accepted request yields
  // exactly one done pulse, every rejected one exactly one err pulse.
  typedef enum logic [1:0] {IDLE, DRIVE, LOAD, DONE} state_t;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] EXT = SW'(R);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [SW-1:0] src_q, src_nx;
  logic [SW-1:0] dst_q, dst_nx;
  logic [R-1:0]  oe_nx, load_nx;
  logic          ext_drv, ext_nx;
  logic          busy_nx, done_nx, err_nx;
  logic          req_bad;

  function automatic logic [R-1:0] one_hot(input logic [SW-1:0] idx);
    return (idx >= EXT) ? '0 : (R'(1) << idx);
  endfunction

  assign req_bad = (dst >= EXT) || (src > EXT) || (src == dst);
  assign bus     = ext_drv ? din : {N{1'bz}};

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    src_nx   = src_q;
    dst_nx   = dst_q;
    oe_nx    = '0;
    load_nx  = '0;
    ext_nx   = 1'b0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (req_bad) begin
            err_nx = 1'b1;
          end else begin
            src_nx   = src;
            dst_nx   = dst;
            cnt_nx   = CW'(SETTLE - 1);
            state_nx = DRIVE;
            busy_nx  = 1'b1;
            oe_nx    = one_hot(src);
            ext_nx   = (src == EXT);
          end
        end
      end
      DRIVE: begin
        // Source drive stays on through LOAD so the destination sees hold time.
        busy_nx = 1'b1;
        oe_nx   = one_hot(src_q);
        ext_nx  = (src_q == EXT);
        if (cnt == '0) begin
          state_nx = LOAD;
          load_nx  = one_hot(dst_q);
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      LOAD: begin
        busy_nx  = 1'b1;
        done_nx  = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      oe      <= '0;
      load    <= '0;
      ext_drv <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bus_q   <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      src_q   <= src_nx;
      dst_q   <= dst_nx;
      oe      <= oe_nx;
      load    <= load_nx;
      ext_drv <= ext_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      err     <= err_nx;
      if (state == LOAD) bus_q <= bus;
    end
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: register banks on the tri-state bus, a cycle-indexed
// expectation schedule for SETTLE=1, and directed SETTLE=3 timing/abort checks.
module tb_bus_xfer_ctrl;
  localparam int N = 8, R = 4, SW = 3, DEPTH = 2048;
  localparam int S1 = 1, S3 = 3;
  localparam logic [SW-1:0] RL = 3'd4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req, req3;
  logic [SW-1:0] src, dst, src3, dst3;
  logic [N-1:0]  din, din3;
  wire  [N-1:0]  bus, bus3;
  logic [R-1:0]  oe, load, oe3, load3;
  logic          busy, done, err, busy3, done3, err3;
  logic [N-1:0]  bus_q, bus_q3;

  logic [N-1:0] regs  [R] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [N-1:0] regs3 [R] = '{8'h11, 8'h22, 8'h33, 8'h44};

  bus_xfer_ctrl #(.N(N), .R(R), .SETTLE(S1)) u_dut (
    .clk(clk), .reset(reset), .req(req), .src(src), .dst(dst), .din(din),
    .bus(bus), .oe(oe), .load(load), .busy(busy), .done(done), .err(err),
    .bus_q(bus_q));

  bus_xfer_ctrl #(.N(N), .R(R), .SETTLE(S3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req3), .src(src3), .dst(dst3), .din(din3),
    .bus(bus3), .oe(oe3), .load(load3), .busy(busy3), .done(done3), .err(err3),
    .bus_q(bus_q3));

  for (genvar i = 0; i < R; i++) begin : g_bank
    assign bus  = oe[i]  ? regs[i]  : {N{1'bz}};
    assign bus3 = oe3[i] ? regs3[i] : {N{1'bz}};
  end

  always @(posedge clk) begin
    for (int i = 0; i < R; i++) begin
      if (load[i])  regs[i]  <= bus;
      if (load3[i]) regs3[i] <= bus3;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected behaviour per cycle index, filled when a request is issued.
  logic [R-1:0] e_oe [DEPTH];
  logic [R-1:0] e_load [DEPTH];
  logic [N-1:0] e_bus [DEPTH];
  logic         e_busy [DEPTH];
  logic         e_done [DEPTH];
  logic         e_err [DEPTH];
  logic         e_bchk [DEPTH];
  logic [N-1:0] mdl_regs [R] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [N-1:0] mdl3 [R] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [SW+N-1:0] exp_q[$];

  int   cyc = 0;
  int   free_cyc = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: per-cycle strobe timing plus scoreboard pop on every done.
  always @(negedge clk) begin
    if (chk_en && cyc < DEPTH) begin
      check("oe", 32'(oe), 32'(e_oe[cyc]));
      check("load", 32'(load), 32'(e_load[cyc]));
      check("busy", 32'(busy), 32'(e_busy[cyc]));
      check("done", 32'(done), 32'(e_done[cyc]));
      check("err", 32'(err), 32'(e_err[cyc]));
      if (e_bchk[cyc]) check("bus", 32'(bus), 32'(e_bus[cyc]));
      if (done) begin
        check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [SW+N-1:0] ent;
          ent = exp_q.pop_front();
          check("bus_q", 32'(bus_q), 32'(ent[N-1:0]));
          check("dst_reg", 32'(regs[ent[SW+N-1:N]]), 32'(ent[N-1:0]));
        end
      end
    end
  end

  // Drive one cycle of inputs to the SETTLE=1 instance and extend the schedule.
  task automatic drive(input logic r, input logic [SW-1:0] s, input logic [SW-1:0] d,
                       input logic [N-1:0] di);
    int c, e;
    logic [N-1:0] v;
    @(posedge clk); #1;
    c = cyc;
    req = r; src = s; dst = d;
    if (c >= free_cyc) din = di;
    if (r && c >= free_cyc) begin
      if (d >= RL || s > RL || s == d) begin
        e_err[c+1] = 1'b1;
      end else begin
        e = c + 1;
        v = (s == RL) ? din : mdl_regs[s];
        for (int k = 0; k <= S1 + 1; k++) e_busy[e+k] = 1'b1;
        for (int k = 0; k <= S1; k++) begin
          e_bchk[e+k] = 1'b1;
          e_bus[e+k]  = v;
          if (s != RL) e_oe[e+k] = 4'b0001 << s;
        end
        e_load[e+S1]   = 4'b0001 << d;
        e_done[e+S1+1] = 1'b1;
        free_cyc = e + S1 + 2;
        exp_q.push_back({d, v});
        mdl_regs[d] = v;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, src, dst, din);
  endtask

  // One SETTLE=3 transfer, measuring the phases relative to the accept edge.
  task automatic run3(input logic [SW-1:0] s, input logic [SW-1:0] d, input logic [N-1:0] di);
    int drv_len, src_len, ld_at, done_at, busy_len, multi;
    logic [R-1:0] ld_val;
    logic active;
    logic [N-1:0] v;
    drv_len = 0; src_len = 0; ld_at = -1; done_at = -1; busy_len = 0; multi = 0; ld_val = '0;
    v = (s == RL) ? di : mdl3[s];
    @(posedge clk); #1;
    req3 = 1'b1; src3 = s; dst3 = d; din3 = di;
    @(posedge clk); #1;
    req3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      active = (s == RL) ? (bus3 === di) : (oe3 == (4'b0001 << s));
      if ($countones(oe3) > 1) multi++;
      if (active) src_len++;
      if (active && load3 == '0) drv_len++;
      if (load3 != '0) begin ld_at = k; ld_val = load3; end
      if (done3) done_at = k;
      if (busy3) busy_len++;
    end
    mdl3[d] = v;
    check("s3_drive_len", 32'(drv_len), 32'(S3));
    check("s3_src_len", 32'(src_len), 32'(S3 + 1));
    check("s3_load_at", 32'(ld_at), 32'(S3));
    check("s3_load_val", 32'(ld_val), 32'(4'b0001 << d));
    check("s3_done_at", 32'(done_at), 32'(S3 + 1));
    check("s3_busy_len", 32'(busy_len), 32'(S3 + 2));
    check("s3_single_drv", 32'(multi), 32'd0);
    check("s3_bus_q", 32'(bus_q3), 32'(v));
    check("s3_dst_reg", 32'(regs3[d]), 32'(v));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [SW-1:0] s, d;
    int nd;
    for (int i = 0; i < DEPTH; i++) begin
      e_oe[i] = '0; e_load[i] = '0; e_bus[i] = '0;
      e_busy[i] = 1'b0; e_done[i] = 1'b0; e_err[i] = 1'b0; e_bchk[i] = 1'b0;
    end
    reset = 1'b0;
    req = 1'b1; src = RL; dst = 3'd2; din = 8'hA5;
    req3 = 1'b1; src3 = RL; dst3 = 3'd0; din3 = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      check("rst_oe", 32'(oe), 32'd0);
      check("rst_load", 32'(load), 32'd0);
      check("rst_flags", 32'({busy, done, err}), 32'd0);
      check("rst_bus_q", 32'(bus_q), 32'd0);
      check("rst_ext_off", 32'(bus === din), 32'd0);
      check("rst3_strobes", 32'({oe3, load3, busy3, done3, err3}), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1; req = 1'b0; req3 = 1'b0;
    free_cyc = 0;
    chk_en = 1'b1;

    drive(1'b1, RL, 3'd2, 8'hA5);   idle(4);
    drive(1'b1, RL, 3'd1, 8'h3C);   idle(4);
    drive(1'b1, 3'd1, 3'd3, 8'h00); idle(4);
    drive(1'b1, 3'd2, 3'd2, 8'h00); idle(1);
    drive(1'b1, 3'd0, 3'd5, 8'h00); idle(1);
    drive(1'b1, 3'd6, 3'd0, 8'h00); idle(2);

    for (int i = 0; i < 12; i++) begin
      d = 3'($urandom_range(0, 3));
      s = 3'($urandom_range(0, 4));
      if (s == d) s = RL;
      drive(1'b1, s, d, 8'($urandom_range(0, 255)));
    end
    idle(4);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 2) != 0, 3'($urandom_range(0, 5)),
            3'($urandom_range(0, 4)), 8'($urandom_range(0, 255)));
    end
    idle(6);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // Abort the SETTLE=1 instance inside its LOAD cycle.
    chk_en = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; src = 3'd0; dst = 3'd3;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check("ab_in_load", 32'({oe, load}), 32'({4'b0001, 4'b1000}));
    reset = 1'b0;
    #1;
    check("ab_oe", 32'(oe), 32'd0);
    check("ab_load", 32'(load), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    nd = 0;
    repeat (2) begin @(negedge clk); if (done) nd++; end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) begin @(negedge clk); if (done || busy) nd++; end
    check("ab_no_done", 32'(nd), 32'd0);
    check("ab_dst_kept", 32'(regs[3]), 32'(mdl_regs[3]));
    free_cyc = 0;
    chk_en = 1'b1;
    drive(1'b1, 3'd0, 3'd3, din); idle(5);
    chk_en = 1'b0;
    check("sb_drained2", 32'(exp_q.size()), 32'd0);

    // SETTLE=3: drive length, then abort in LOAD, then a clean transfer again.
    run3(RL, 3'd0, 8'h5A);
    run3(3'd0, 3'd3, 8'h00);
    @(posedge clk); #1;
    req3 = 1'b1; src3 = 3'd1; dst3 = 3'd2;
    @(posedge clk); #1;
    req3 = 1'b0;
    repeat (S3) @(posedge clk);
    #1;
    check("ab3_in_load", 32'(load3), 32'(4'b0100));
    reset = 1'b0;
    #1;
    check("ab3_strobes", 32'({oe3, load3}), 32'd0);
    check("ab3_busy", 32'(busy3), 32'd0);
    nd = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) begin @(negedge clk); if (done3 || busy3) nd++; end
    check("ab3_no_done", 32'(nd), 32'd0);
    check("ab3_dst_kept", 32'(regs3[2]), 32'(mdl3[2]));
    run3(3'd3, 3'd1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
